// File: rtl/turn_signal_pkg.sv
// Shared types for the tail-light turn-signal sequencer.
// The mode encoding doubles as the external mode port value.
package turn_signal_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT,
        ST_HAZ_ON
    } state_t;

endpackage

// File: rtl/blink_tick_gen.sv
// Blink-step prescaler: tick is high for one clock every TICK_DIV clocks.
// With TICK_DIV=1 the counter never leaves zero, so tick is constantly high.
module blink_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/turn_signal_seq_n.sv
// N-lamp-per-side turn-signal sequencer with hazard mode and step prescaler.
// State, position and lamp outputs all advance only on prescaler ticks.
module turn_signal_seq_n
    import turn_signal_pkg::*;
#(
    parameter int N_LAMPS   = 3,
    parameter int TICK_DIV  = 1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    output logic [N_LAMPS-1:0] l_lamps,
    output logic [N_LAMPS-1:0] r_lamps,
    output logic               busy,
    output logic [1:0]         mode
);

    localparam int POS_W = $clog2(N_LAMPS + 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LAMPS);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    state_t             r_state;
    mode_t              r_mode;
    logic [POS_W-1:0]   r_pos;
    logic [N_LAMPS-1:0] r_l_lamps;
    logic [N_LAMPS-1:0] r_r_lamps;
    logic               r_busy;
    logic               w_tick;

    // Lowest k lamps lit; k == N_LAMPS lights the whole side.
    function automatic logic [N_LAMPS-1:0] thermo(input logic [POS_W-1:0] k);
        return ~({N_LAMPS{1'b1}} << k);
    endfunction

    blink_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    // NOTE: outputs are decoded from the next state inside the same register stage, so lamps never glitch on inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_IDLE;
            r_pos     <= '0;
            r_l_lamps <= '0;
            r_r_lamps <= '0;
            r_busy    <= 1'b0;
        end else if (w_tick) begin
            // Every branch falls back to IDLE unless it claims another state below.
            r_state   <= ST_IDLE;
            r_mode    <= MODE_IDLE;
            r_pos     <= '0;
            r_l_lamps <= '0;
            r_r_lamps <= '0;
            r_busy    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (left && !right) begin
                        r_state   <= ST_LEFT;
                        r_mode    <= MODE_LEFT;
                        r_pos     <= POS_ONE;
                        r_l_lamps <= thermo(POS_ONE);
                        r_busy    <= 1'b1;
                    end else if (right && !left) begin
                        r_state   <= ST_RIGHT;
                        r_mode    <= MODE_RIGHT;
                        r_pos     <= POS_ONE;
                        r_r_lamps <= thermo(POS_ONE);
                        r_busy    <= 1'b1;
                    end else if (left && right && HAZARD_EN) begin
                        r_state   <= ST_HAZ_ON;
                        r_mode    <= MODE_HAZARD;
                        r_l_lamps <= '1;
                        r_r_lamps <= '1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_LEFT: begin
                    if (r_pos < POS_MAX) begin
                        r_state   <= ST_LEFT;
                        r_mode    <= MODE_LEFT;
                        r_pos     <= r_pos + POS_ONE;
                        r_l_lamps <= thermo(r_pos + POS_ONE);
                        r_busy    <= 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (r_pos < POS_MAX) begin
                        r_state   <= ST_RIGHT;
                        r_mode    <= MODE_RIGHT;
                        r_pos     <= r_pos + POS_ONE;
                        r_r_lamps <= thermo(r_pos + POS_ONE);
                        r_busy    <= 1'b1;
                    end
                end
                ST_HAZ_ON: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign l_lamps = r_l_lamps;
    assign r_lamps = r_r_lamps;
    assign busy    = r_busy;
    assign mode    = r_mode;

endmodule

// File: tb/tb_turn_signal_seq_n.sv
// Table-driven bench for turn_signal_seq_n across three parameter sets
// sharing one stimulus stream; each vector names the instance it checks.
module tb_turn_signal_seq_n;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left = 1'b0;
    logic right = 1'b0;

    logic [2:0] l_a, r_a, l_b, r_b;
    logic [3:0] l_c, r_c;
    logic [1:0] m_a, m_b, m_c;
    logic       b_a, b_b, b_c;

    always #5 clk = ~clk;

    // Instance 0: N=3, TICK_DIV=1, hazard disabled.
    turn_signal_seq_n #(.N_LAMPS(3), .TICK_DIV(1), .HAZARD_EN(1'b0)) dut_a (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .l_lamps(l_a), .r_lamps(r_a), .busy(b_a), .mode(m_a)
    );

    // Instance 1: N=3, TICK_DIV=1, hazard enabled.
    turn_signal_seq_n #(.N_LAMPS(3), .TICK_DIV(1), .HAZARD_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .l_lamps(l_b), .r_lamps(r_b), .busy(b_b), .mode(m_b)
    );

    // Instance 2: N=4, TICK_DIV=3.
    turn_signal_seq_n #(.N_LAMPS(4), .TICK_DIV(3), .HAZARD_EN(1'b1)) dut_c (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .l_lamps(l_c), .r_lamps(r_c), .busy(b_c), .mode(m_c)
    );

    typedef struct {
        int         dut;
        bit         rst;
        bit         lft;
        bit         rgt;
        logic [3:0] exp_l;
        logic [3:0] exp_r;
        logic [1:0] exp_mode;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input int dut, input bit rst, input bit lft, input bit rgt,
                       input logic [3:0] el, input logic [3:0] er, input logic [1:0] em);
        vec_t v;
        v.dut      = dut;
        v.rst      = rst;
        v.lft      = lft;
        v.rgt      = rgt;
        v.exp_l    = el;
        v.exp_r    = er;
        v.exp_mode = em;
        v.exp_busy = (em != 2'd0);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s vec%0d: got %b want %b", name, idx, got, want);
        end
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] el;
        logic [1:0] em;
        vec_t       e;
        logic [3:0] act_l, act_r;
        logic [1:0] act_m;
        logic       act_b;
        one = 4'd1;

        // Instance 0: reset and idle.
        add(0, 1, 0, 0, 4'h0, 4'h0, 2'd0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 2'd0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 2'd0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 2'd0);
        // Both pressed with hazard disabled: stays idle.
        add(0, 0, 1, 1, 4'h0, 4'h0, 2'd0);
        add(0, 0, 1, 1, 4'h0, 4'h0, 2'd0);
        // Single right pulse runs a full sweep.
        add(0, 0, 0, 1, 4'h0, 4'h1, 2'd2);
        add(0, 0, 0, 0, 4'h0, 4'h3, 2'd2);
        add(0, 0, 0, 0, 4'h0, 4'h7, 2'd2);
        add(0, 0, 0, 0, 4'h0, 4'h0, 2'd0);
        // Inputs during a left sweep are ignored.
        add(0, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(0, 0, 0, 1, 4'h3, 4'h0, 2'd1);
        add(0, 0, 1, 1, 4'h7, 4'h0, 2'd1);
        add(0, 0, 1, 1, 4'h0, 4'h0, 2'd0);
        // Held left repeats with period N+1.
        for (int i = 0; i < 8; i++) begin
            el = (i % 4 == 3) ? 4'h0 : (one << ((i % 4) + 1)) - 4'd1;
            em = (i % 4 == 3) ? 2'd0 : 2'd1;
            add(0, 0, 1, 0, el, 4'h0, em);
        end
        // Reset mid-sweep wins, also over a new request.
        add(0, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(0, 0, 1, 0, 4'h3, 4'h0, 2'd1);
        add(0, 1, 0, 0, 4'h0, 4'h0, 2'd0);
        add(0, 1, 0, 1, 4'h0, 4'h0, 2'd0);
        add(0, 1, 0, 1, 4'h0, 4'h0, 2'd0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 2'd0);

        // Instance 1: hazard alternates on/off while both are held.
        add(1, 1, 0, 0, 4'h0, 4'h0, 2'd0);
        add(1, 0, 1, 1, 4'h7, 4'h7, 2'd3);
        add(1, 0, 1, 1, 4'h0, 4'h0, 2'd0);
        add(1, 0, 1, 1, 4'h7, 4'h7, 2'd3);
        add(1, 0, 1, 1, 4'h0, 4'h0, 2'd0);
        add(1, 0, 0, 0, 4'h0, 4'h0, 2'd0);
        // Hazard exits to idle regardless of inputs, then a left sweep can start.
        add(1, 0, 1, 1, 4'h7, 4'h7, 2'd3);
        add(1, 0, 1, 0, 4'h0, 4'h0, 2'd0);
        add(1, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(1, 0, 0, 0, 4'h3, 4'h0, 2'd1);

        // Instance 2: each step lasts three clocks; first tick is the third edge after reset.
        add(2, 1, 0, 0, 4'h0, 4'h0, 2'd0);
        for (int c = 1; c <= 18; c++) begin
            int k;
            k  = (c / 3) % 5;
            el = (one << k) - 4'd1;
            em = (k == 0) ? 2'd0 : 2'd1;
            add(2, 0, 1, 0, el, 4'h0, em);
        end
        // Reset in mid-prescale restarts the phase.
        add(2, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(2, 1, 1, 0, 4'h0, 4'h0, 2'd0);
        add(2, 0, 1, 0, 4'h0, 4'h0, 2'd0);
        add(2, 0, 1, 0, 4'h0, 4'h0, 2'd0);
        add(2, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(2, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(2, 0, 1, 0, 4'h1, 4'h0, 2'd1);
        add(2, 0, 1, 0, 4'h3, 4'h0, 2'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            left  = vecs[i].lft;
            right = vecs[i].rgt;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            case (e.dut)
                0:       begin act_l = {1'b0, l_a}; act_r = {1'b0, r_a}; act_m = m_a; act_b = b_a; end
                1:       begin act_l = {1'b0, l_b}; act_r = {1'b0, r_b}; act_m = m_b; act_b = b_b; end
                default: begin act_l = l_c;         act_r = r_c;         act_m = m_c; act_b = b_c; end
            endcase
            check($sformatf("dut%0d l_lamps", e.dut), i, act_l, e.exp_l);
            check($sformatf("dut%0d r_lamps", e.dut), i, act_r, e.exp_r);
            check($sformatf("dut%0d mode", e.dut), i, {2'b00, act_m}, {2'b00, e.exp_mode});
            check($sformatf("dut%0d busy", e.dut), i, {3'b000, act_b}, {3'b000, e.exp_busy});
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
